addsub_serial: RTL

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_digit.sv | 22 ++
 rtl/addsub_serial.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : addsub_pkg

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit slice adder; also reports the carry into its top bit
// so the parent can form signed overflow on the final slice.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ctop
);

    logic [DIGIT:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
    assign o_sum  = w_full[DIGIT-1:0];
    assign o_cout = w_full[DIGIT];
    // sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly
    assign o_ctop = i_a[DIGIT-1] ^ i_b[DIGIT-1] ^ w_full[DIGIT-1];

endmodule : addsub_digit

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract: one DIGIT-bit slice per RUN cycle, LSB first,
// with flags captured on the edge that raises done.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_done;
    logic               r_co;
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [DIGIT-1:0]   w_sum;
    logic               w_cout;
    logic               w_ctop;
    logic [WIDTH-1:0]   w_res_next;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ctop (w_ctop)
    );

    // New slice enters at the top; after N steps the result is fully aligned.
    if (WIDTH == DIGIT) begin : g_res_one
        assign w_res_next = w_sum;
    end else begin : g_res_many
        assign w_res_next = {w_sum, r_res[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = start;
            end
            RUN: begin
                w_step = 1'b1;
                w_last = (r_cnt == CNT_W'(N - 1));
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Operand capture, slice accumulation and flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_co    <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_cnt   <= '0;
                r_carry <= mode;
                r_a     <= a;
                r_b     <= (mode == MODE_SUB) ? ~b : b;
            end else if (w_step) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_carry <= w_cout;
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_res   <= w_res_next;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_co   <= w_cout;
                    r_zero <= (w_res_next == '0);
                    r_neg  <= w_res_next[WIDTH-1];
                    r_ovf  <= w_ctop ^ w_cout;
                end else begin
                    r_done <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign res  = r_res;
    assign co   = r_co;
    assign zero = r_zero;
    assign neg  = r_neg;
    assign ovf  = r_ovf;

endmodule : addsub_serial
